// File: rtl/led_array_pkg.sv
// -----------------------------------------------------------------------------
// led_array_pkg
// Shared constants for the LED array driver slice.
//   LED_DEFAULT_N  : default side length of the square LED array
//   led_x_width()  : width of a column index able to also express N itself
//   LED_X_W        : index width for the default array size
// -----------------------------------------------------------------------------
package led_array_pkg;

    localparam int LED_DEFAULT_N = 8;

    // One extra bit so that an index equal to N (one past the last column)
    // can be presented and recognised as out of range.
    function automatic int led_x_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int LED_X_W = led_x_width(LED_DEFAULT_N);

endpackage

// File: rtl/led_array_driver_one_hot_decoder.sv
// -----------------------------------------------------------------------------
// one_hot_decoder
// Combinational index-to-one-hot decoder.
// Ports:
//   i_idx    : index, wide enough to also hold values >= W
//   i_en     : enable; low forces an all-zero output
//   o_onehot : bit i_idx set when enabled and i_idx < W, otherwise zero
// -----------------------------------------------------------------------------
module one_hot_decoder
    import led_array_pkg::*;
#(
    parameter int W     = LED_DEFAULT_N,
    parameter int IDX_W = led_x_width(W)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [W-1:0]     o_onehot
);

    // An index >= W matches no output position, so out-of-range
    // values fall through to zero without a separate range check.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < W; k++) begin
            o_onehot[k] = i_en && (i_idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/led_array_model.sv
// -----------------------------------------------------------------------------
// led_array_model
// Simulation-only viewer for the LED array outputs.
// Ports:
//   rows : row drive from led_array_driver
//   cols : column select from led_array_driver
// Task print_status prints the lit pattern, row 0 on the top line,
// '#' for a lit LED (rows[r] & cols[c]) and '.' for a dark one.
// -----------------------------------------------------------------------------
`ifdef SIMULATION
module led_array_model #(
    parameter int N = 8
) (
    input logic [N-1:0] rows,
    input logic [N-1:0] cols
);

    task automatic print_status();
        string line;
        for (int r = 0; r < N; r++) begin
            line = "";
            for (int c = 0; c < N; c++) begin
                line = {line, (rows[r] && cols[c]) ? "#" : "."};
            end
            $display("row %0d: %s", r, line);
        end
    endtask

endmodule
`endif

// File: rtl/led_array_driver.sv
// -----------------------------------------------------------------------------
// led_array_driver
// Scans one column of an N x N LED frame buffer per clock: drives the
// selected column one-hot and the row lines with that column's pixels.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, blanks the outputs at once
//   ena   : display enable, 0 blanks the array
//   cells : frame buffer, bit N*r+c is the LED at row r, column c
//   x     : column to scan; values >= N blank the array
//   rows  : registered active-high row drive
//   cols  : registered active-high one-hot column select
// -----------------------------------------------------------------------------
module led_array_driver
    import led_array_pkg::*;
#(
    parameter int N    = LED_DEFAULT_N,
    parameter int ROWS = N,
    parameter int COLS = N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [N*N-1:0]            cells,
    input  logic [led_x_width(N)-1:0] x,
    output logic [ROWS-1:0]           rows,
    output logic [COLS-1:0]           cols
);

    localparam int XW = led_x_width(N);

    if (ROWS != N || COLS != N) begin : g_bad_geometry
        $error("led_array_driver: ROWS and COLS must both equal N");
    end

    // Slice k holds ones at bits N*r+k: the pixels belonging to column k.
    function automatic logic [N*N*N-1:0] build_masks();
        logic [N*N*N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < N; r++) begin
                m[N*N*k + N*r + k] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [N*N*N-1:0] COLUMN_MASKS = build_masks();

    logic            w_in_range;
    logic            w_valid;
    logic [XW-1:0]   w_col_idx;
    logic [N*N-1:0]  w_masked;
    logic [N-1:0]    w_rows;
    logic [COLS-1:0] w_cols;

    logic [ROWS-1:0] r_rows;
    logic [COLS-1:0] r_cols;

    assign w_in_range = (x < XW'(N));
    assign w_valid    = ena && w_in_range;

    // Clamp the index so the mask slice never addresses past the table;
    // the clamped value is irrelevant because w_valid gates the rows.
    assign w_col_idx = w_in_range ? x : '0;
    assign w_masked  = cells & COLUMN_MASKS[N*N*w_col_idx +: N*N];

    // Each row group holds at most one surviving bit, so OR-reducing the
    // group compresses the masked frame down to one bit per row.
    always_comb begin
        w_rows = '0;
        for (int r = 0; r < N; r++) begin
            w_rows[r] = w_valid && (|w_masked[N*r +: N]);
        end
    end

    one_hot_decoder #(
        .W     (COLS),
        .IDX_W (XW)
    ) u_col_dec (
        .i_idx    (x),
        .i_en     (ena),
        .o_onehot (w_cols)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows <= '0;
            r_cols <= '0;
        end else begin
            r_rows <= w_rows;
            r_cols <= w_cols;
        end
    end

    assign rows = r_rows;
    assign cols = r_cols;

endmodule

// File: tb/tb_led_array_driver.sv
// -----------------------------------------------------------------------------
// tb_led_array_driver
// Directed and random stimulus for led_array_driver (N=8), compared against a
// frame-level reference model held in the bench.
// -----------------------------------------------------------------------------
module tb_led_array_driver;

    localparam int N = 8;

    logic          clk;
    logic          rst;
    logic          ena;
    logic [N*N-1:0] cells;
    logic [3:0]    x;
    logic [N-1:0]  rows;
    logic [N-1:0]  cols;

    int errors = 0;
    int checks = 0;

    led_array_driver #(.N(N), .ROWS(N), .COLS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .cells (cells),
        .x     (x),
        .rows  (rows),
        .cols  (cols)
    );

`ifdef SIMULATION
    led_array_model #(.N(N)) u_model (
        .rows (rows),
        .cols (cols)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: view the frame as a 2-D picture and read out one column.
    function automatic logic [N-1:0] ref_rows(input logic e, input logic [N*N-1:0] f,
                                               input int col);
        logic pic [N][N];
        logic [N-1:0] out;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                pic[r][c] = f[N*r + c];
        out = '0;
        if (e && col < N)
            for (int r = 0; r < N; r++)
                out[r] = pic[r][col];
        return out;
    endfunction

    function automatic logic [N-1:0] ref_cols(input logic e, input int col);
        logic [N-1:0] out;
        out = '0;
        if (e && col < N) out[col] = 1'b1;
        return out;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0]   er, ec;
        logic [N*N-1:0] f;
        logic           e;
        int             xv;

        // Reset held with live inputs: outputs stay blank immediately and
        // across clock edges.
        rst   = 1'b1;
        ena   = 1'b1;
        cells = '1;
        x     = 4'd0;
        #1;
        chk("reset_rows_immediate", rows, 8'h00);
        chk("reset_cols_immediate", cols, 8'h00);
        repeat (2) begin
            edge_wait();
            chk("reset_rows_held", rows, 8'h00);
            chk("reset_cols_held", cols, 8'h00);
        end

        // Blanking.
        rst = 1'b0;
        ena = 1'b0;
        edge_wait();
        chk("blank_rows", rows, 8'h00);
        chk("blank_cols", cols, 8'h00);

        // Single-LED walk over every LED and every column position.
        ena = 1'b1;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                f = '0;
                f[N*j + i] = 1'b1;
                for (int xi = 0; xi < N; xi++) begin
                    cells = f;
                    x     = 4'(xi);
                    edge_wait();
                    er = (xi == i) ? 8'(1 << j) : 8'h00;
                    ec = 8'(1 << xi);
                    chk($sformatf("walk_rows j%0d i%0d x%0d", j, i, xi), rows, er);
                    chk($sformatf("walk_cols j%0d i%0d x%0d", j, i, xi), cols, ec);
`ifdef SIMULATION
                    if (j == 2 && i == 5 && xi == 5) u_model.print_status();
`endif
                end
            end
        end

        // Full frame.
        cells = '1;
        ena   = 1'b1;
        x     = 4'd3;
        edge_wait();
        chk("full_rows", rows, 8'hFF);
        chk("full_cols", cols, 8'h08);

        // Out of range, including every value above N.
        for (int xi = N; xi < 16; xi++) begin
            x = 4'(xi);
            edge_wait();
            chk($sformatf("oor_rows x%0d", xi), rows, 8'h00);
            chk($sformatf("oor_cols x%0d", xi), cols, 8'h00);
        end

        // Random frames, enables and indices changing together every cycle.
        for (int n = 0; n < 400; n++) begin
            f  = {$urandom, $urandom};
            e  = ($urandom_range(0, 9) != 0);
            xv = ($urandom_range(0, 3) != 0) ? $urandom_range(0, N-1)
                                             : $urandom_range(N, 15);
            cells = f;
            ena   = e;
            x     = 4'(xv);
            edge_wait();
            chk($sformatf("rand_rows n%0d", n), rows, ref_rows(e, f, xv));
            chk($sformatf("rand_cols n%0d", n), cols, ref_cols(e, xv));
        end

        // Mid-operation asynchronous reset, then normal recovery.
        cells = '1;
        ena   = 1'b1;
        x     = 4'd5;
        edge_wait();
        chk("mid_pre_rows", rows, 8'hFF);
        #3 rst = 1'b1;
        #1;
        chk("mid_async_rows", rows, 8'h00);
        chk("mid_async_cols", cols, 8'h00);
        #2 rst = 1'b0;
        #1;
        chk("mid_release_rows", rows, 8'h00);
        edge_wait();
        chk("mid_recover_rows", rows, 8'hFF);
        chk("mid_recover_cols", cols, 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
